md_hilo_unit: RTL and testbench
===============================

# md_hilo_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS54 single-cycle core. It executes MULT, MULTU, DIV and DIVU over multiple cycles and accepts direct MTHI/MTLO writes. It also drives the 32-bit HI and LO values that the core's write-back select muxes pick from for MFHI and MFLO. The control unit stalls the PC while `busy` is high.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request, sampled on the rising edge of `clk`.
- `op`  in  5  one-hot operation select: 5'b00001 MULT, 5'b00010 MULTU, 5'b00100 DIV, 5'b01000 DIVU. Bit 4 is reserved and must be 0.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `mthi_we`  in  1  write `wdata` into HI.
- `mtlo_we`  in  1  write `wdata` into LO.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO were updated on this edge.

## Operation
- States:
  - IDLE → RUN: `start`=1 and `op` is exactly one of the four legal codes.
  - RUN → FIX: after 32 iterations.
  - FIX → IDLE: HI/LO written, `done`=1.
- Launch edge:
  - Latch `a`, `b` and `op`.
  - For signed ops, store |a| and |b| and record the result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 6-bit iteration counter.
- Multiply, RUN:
  - Shift-add over a 64-bit accumulator.
  - Each cycle: if multiplier LSB=1, add the multiplicand to the upper 33 bits, then shift the accumulator right by 1.
- Divide, RUN:
  - Restoring division over a 64-bit {remainder, quotient} register.
  - Each cycle: shift left by 1, trial-subtract the divisor from the upper 33 bits, and keep the result if it is non-negative (quotient bit = 1).
- FIX state:
  - Signed ops: negate the product, quotient and remainder as the recorded signs require (two's complement, 64-bit for the product).
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (b=0, DIV or DIVU): takes the normal 33-cycle path, then HI = a (raw, unnegated) and LO = 32'hFFFFFFFF. No exception.
- DIV with a=32'h80000000, b=32'hFFFFFFFF: LO = 32'h80000000, HI = 0 (wraps, no trap).
- `start` while `busy`=1: ignored.
- `start` with an illegal `op` (zero, multi-hot, or bit 4 set): ignored; no state change.
- MTHI/MTLO:
  - Accepted only in IDLE; updates the register on the next edge; no `done` pulse.
  - Both write enables may be asserted in the same cycle.
  - Ignored while `busy`.
  - If `start` and a write enable arrive on the same IDLE edge, the write takes effect and the operation launches; the operation's result overwrites it later.

## Timing
- Reset (asynchronous, on `rst_n` low): `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset during RUN or FIX aborts the operation: HI/LO = 0, no `done`.
- Latency from launch edge N:
  - `busy`=1 from edge N through the cycle before edge N+33.
  - At edge N+33 HI/LO are written, `done`=1 for exactly one cycle and `busy`=0.
- Back-to-back: `start` asserted during the `done` cycle is accepted at edge N+34.
- `hi` and `lo` are registered outputs; they never show intermediate iteration values.

## Configuration
- `MD_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `*` product, with signed or unsigned operand casting per `op`.
  - Launch edge N goes IDLE → FIX; HI/LO are written and `done` pulses at edge N+1; `busy`=1 for one cycle.
  - Divides are unchanged.
- `MD_FAST_MUL_EN` undefined: all four ops take the iterative 33-cycle path described above.

## Test plan
- MULT a=32'hFFFFFFFD (−3), b=5 → at edge N+33: HI=32'hFFFFFFFF, LO=32'hFFFFFFF1, `done` pulses once. With `MD_FAST_MUL_EN`, the same result at edge N+1.
- MULTU a=32'hFFFFFFFF, b=2 → HI=1, LO=32'hFFFFFFFE.
- DIVU a=100, b=7 → LO=14, HI=2. DIV a=−7, b=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU a=123, b=0 → HI=123, LO=32'hFFFFFFFF at edge N+33.
- Launch DIV, pulse `start` with MULT at edge N+5, pulse `mthi_we` with wdata=32'h55 at edge N+6 → both ignored; only the DIV result appears, at edge N+33.
- Launch MULT, drop `rst_n` at edge N+10 → `busy`=0, HI=LO=0 immediately, no `done`. After release, MTLO wdata=32'hA5A5 → `lo`=32'hA5A5 next edge.

Source files
------------

// File: rtl/md_hilo_unit.sv
// rtl/md_hilo_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
// Optional MD_FAST_MUL_EN: single-cycle multiply; divides stay iterative.
module md_hilo_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_lo, neg_hi;
    logic [31:0] dvs;
    logic [63:0] acc;

    logic        op_legal, launch, sgn_op, div_op;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [63:0] mul_nx, div_nx, prod_fix;
    logic [33:0] div_diff;
    logic [31:0] quo_fix, rem_fix;

    assign op_legal = (op == 5'b00001) || (op == 5'b00010) ||
                      (op == 5'b00100) || (op == 5'b01000);
    assign launch   = (state == IDLE) && start && op_legal;
    assign sgn_op   = op[0] | op[2];
    assign div_op   = op[2] | op[3];
    assign a_abs    = (sgn_op && a[31]) ? 32'd0 - a : a;
    assign b_abs    = (sgn_op && b[31]) ? 32'd0 - b : b;
    assign busy     = (state != IDLE);

    // Multiply: multiplier sits in acc[31:0] and is consumed from the LSB.
    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, dvs};
    assign mul_nx   = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

    // Divide: trial-subtract against the top 33 bits of the shifted {rem, quo}.
    assign div_diff = {1'b0, acc[63:31]} - {2'b00, dvs};
    assign div_nx   = div_diff[33] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign prod_fix = neg_lo ? 64'd0 - acc : acc;
    assign quo_fix  = neg_lo ? 32'd0 - acc[31:0] : acc[31:0];
    assign rem_fix  = neg_hi ? 32'd0 - acc[63:32] : acc[63:32];

`ifdef MD_FAST_MUL_EN
    logic [63:0] sprod, uprod;
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = RUN;
`ifdef MD_FAST_MUL_EN
                    if (op[0] | op[1])
                        state_nx = FIX;
`endif
                end
            end
            RUN:     if (cnt == 6'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dvs    <= 32'd0;
            acc    <= 64'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi_we) hi <= wdata;
                    if (mtlo_we) lo <= wdata;
                    if (launch) begin
                        is_div <= div_op;
                        dvs    <= div_op ? b_abs : a_abs;
                        acc    <= {32'd0, div_op ? a_abs : b_abs};
                        neg_lo <= sgn_op & (a[31] ^ b[31]);
                        neg_hi <= sgn_op & a[31];
                        cnt    <= 6'd0;
`ifdef MD_FAST_MUL_EN
                        if (op[0]) begin
                            acc    <= sprod;
                            neg_lo <= 1'b0;
                        end else if (op[1]) begin
                            acc    <= uprod;
                            neg_lo <= 1'b0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc <= is_div ? div_nx : mul_nx;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Divide by zero leaves |a| as remainder, so HI restores raw a.
                        hi <= rem_fix;
                        lo <= (dvs == 32'd0) ? 32'hFFFFFFFF : quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// tb/tb_md_hilo_unit.sv - scoreboard testbench for md_hilo_unit
module tb_md_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done;

    localparam logic [4:0] OP_MULT  = 5'b00001;
    localparam logic [4:0] OP_MULTU = 5'b00010;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_DIVU  = 5'b01000;

    md_hilo_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge_n;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [4:0] o);
`ifdef MD_FAST_MUL_EN
        return (o[0] | o[1]) ? 1 : 33;
`else
        return (o == 5'b11111) ? 0 : 33;
`endif
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at edge %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result_hi", hi, mon_e.hi);
                chk("result_lo", lo, mon_e.lo);
                chk("done_edge", 32'(cyc), 32'(mon_e.edge_n));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the launch edge.
    task automatic launch(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic push, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1;
        op = o;
        a = va;
        b = vb;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.edge_n = cyc + 1 + lat(o);
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el);
        launch(o, va, vb, 1'b1, eh, el);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each launch is driven in the done cycle of the previous op.
        run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
        run_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(OP_DIVU,  32'd123,      32'd0,        32'd123,      32'hFFFFFFFF);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0);
        @(negedge clk);

        // start and MTHI while busy are ignored
        launch(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = OP_MULT;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        mthi_we = 1'b1;
        wdata = 32'h55;
        @(negedge clk);
        mthi_we = 1'b0;
        chk("busy_mid_run", 32'(busy), 32'd1);
        wait_done();
        @(negedge clk);

        // illegal op codes never launch
        start = 1'b1;
        op = 5'b10001;
        @(negedge clk);
        chk("illegal_op_bit4", 32'(busy), 32'd0);
        op = 5'b00000;
        @(negedge clk);
        chk("illegal_op_zero", 32'(busy), 32'd0);
        op = 5'b00011;
        @(negedge clk);
        chk("illegal_op_multihot", 32'(busy), 32'd0);
        start = 1'b0;
        chk("illegal_op_hi_kept", hi, 32'd2);

        // simultaneous MTHI/MTLO
        mthi_we = 1'b1;
        mtlo_we = 1'b1;
        wdata = 32'h1234ABCD;
        @(negedge clk);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        chk("mthi_both", hi, 32'h1234ABCD);
        chk("mtlo_both", lo, 32'h1234ABCD);

        // MTHI on the launch edge lands, then the result overwrites it
        mthi_we = 1'b1;
        wdata = 32'hDEAD0000;
        launch(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
        mthi_we = 1'b0;
        chk("mthi_with_start", hi, 32'hDEAD0000);
        wait_done();
        @(negedge clk);

        // reset in mid-operation aborts it
`ifdef MD_FAST_MUL_EN
        launch(OP_DIV, 32'd77, 32'd5, 1'b0, 32'd0, 32'd0);
`else
        launch(OP_MULT, 32'd3, 32'd3, 1'b0, 32'd0, 32'd0);
`endif
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mtlo_we = 1'b1;
        wdata = 32'h0000A5A5;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_after_reset", lo, 32'h0000A5A5);
        chk("hi_after_reset", hi, 32'd0);

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
